// File: rtl/env_note_gen.sv
// env_note_gen
//   Dual-channel square-wave tone generator with an attack/release envelope
//   and a 5-level volume. Ramping the amplitude, rather than switching it,
//   avoids clicks at note boundaries.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | no tone; env = 0
//   ATTACK  | env rises by ATTACK_STEP per tick, saturating at 255
//   SUSTAIN | env held at 255 while the gate stays high
//   RELEASE | env falls by RELEASE_STEP per tick, saturating at 0
//
// Ports
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   note_div_left  in   left half-period in clk cycles (<= 1 means silence)
//   note_div_right in   right half-period in clk cycles (<= 1 means silence)
//   volume         in   0 = mute, 1..5 = levels, 6..7 behave as 5
//   audio_left     out  signed left sample
//   audio_right    out  signed right sample
//   env_state      out  envelope state (0 IDLE, 1 ATTACK, 2 SUSTAIN, 3 RELEASE)
module env_note_gen #(
  parameter int TICK_DIV     = 50000,
  parameter int ATTACK_STEP  = 16,
  parameter int RELEASE_STEP = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [21:0]        note_div_left,
  input  logic [21:0]        note_div_right,
  input  logic [2:0]         volume,
  output logic signed [15:0] audio_left,
  output logic signed [15:0] audio_right,
  output logic [1:0]         env_state
);

  localparam int TW = $clog2(TICK_DIV + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ATTACK  = 2'd1,
    S_SUSTAIN = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t      state_q;
  logic [7:0]  env_q;
  logic [TW-1:0] tick_cnt_q;
  logic        tick;

  logic [21:0] div_in [2];
  logic [21:0] lat_q  [2];
  logic [21:0] cnt_q  [2];
  logic        phase_q[2];

  logic        gate;
  logic        retrig;
  logic [8:0]  env_up;
  logic [7:0]  env_inc;
  logic [7:0]  env_dec;
  logic [15:0] peak;
  logic [23:0] prod;
  logic [15:0] mag;
  logic [15:0] audio_d[2];

  assign div_in[0] = note_div_left;
  assign div_in[1] = note_div_right;

  assign gate = (note_div_left > 22'd1) | (note_div_right > 22'd1);
  // A new left note is seen as a valid divider differing from the latched one,
  // so dropping to silence on the left does not count as a retrigger.
  assign retrig = (note_div_left > 22'd1) && (note_div_left != lat_q[0]);

  assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt_q <= '0;
    else        tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
  end

  assign env_up  = {1'b0, env_q} + 9'(ATTACK_STEP);
  assign env_inc = env_up[8] ? 8'hFF : env_up[7:0];
  assign env_dec = (env_q < 8'(RELEASE_STEP)) ? 8'h00 : env_q - 8'(RELEASE_STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      env_q   <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gate) state_q <= S_ATTACK;
        end
        S_ATTACK: begin
          if (tick) env_q <= env_inc;
          if (!gate)                          state_q <= S_RELEASE;
          else if (env_q == 8'hFF && !retrig) state_q <= S_SUSTAIN;
        end
        S_SUSTAIN: begin
          env_q <= 8'hFF;
          if (!gate)       state_q <= S_RELEASE;
          else if (retrig) state_q <= S_ATTACK;
        end
        S_RELEASE: begin
          if (tick) env_q <= env_dec;
          // Re-attack continues from the current env level.
          if (gate)                state_q <= S_ATTACK;
          else if (env_q == 8'h00) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign env_state = state_q;

  // Oscillators: a new divider restarts the count without toggling the phase;
  // a silent input keeps the last divider so the tone rings through RELEASE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        lat_q[c]   <= '0;
        cnt_q[c]   <= '0;
        phase_q[c] <= 1'b0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (div_in[c] > 22'd1 && div_in[c] != lat_q[c]) begin
          lat_q[c] <= div_in[c];
          cnt_q[c] <= '0;
        end else if (lat_q[c] > 22'd1) begin
          if (cnt_q[c] == lat_q[c] - 22'd1) begin
            cnt_q[c]   <= '0;
            phase_q[c] <= ~phase_q[c];
          end else begin
            cnt_q[c] <= cnt_q[c] + 22'd1;
          end
        end
      end
    end
  end

  always_comb begin
    peak = 16'h0000;
    case (volume)
      3'd0:    peak = 16'h0000;
      3'd1:    peak = 16'h0800;
      3'd2:    peak = 16'h1000;
      3'd3:    peak = 16'h2000;
      3'd4:    peak = 16'h3000;
      default: peak = 16'h3FFF;
    endcase
  end

  assign prod = peak * env_q;
  assign mag  = 16'(prod >> 8);

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      audio_d[c] = 16'h0000;
      if (lat_q[c] > 22'd1 && env_q != 8'h00)
        audio_d[c] = phase_q[c] ? mag : -mag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      audio_left  <= '0;
      audio_right <= '0;
    end else begin
      audio_left  <= audio_d[0];
      audio_right <= audio_d[1];
    end
  end

endmodule

// File: tb/tb_env_note_gen.sv
module tb_env_note_gen;

  logic               clk;
  logic               rst_n;
  logic [21:0]        div_l;
  logic [21:0]        div_r;
  logic [2:0]         vol;
  logic signed [15:0] audio_left;
  logic signed [15:0] audio_right;
  logic [1:0]         env_state;

  int errs = 0;
  int nchk = 0;
  int cyc;

  env_note_gen #(.TICK_DIV(10), .ATTACK_STEP(16), .RELEASE_STEP(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .note_div_left  (div_l),
    .note_div_right (div_r),
    .volume         (vol),
    .audio_left     (audio_left),
    .audio_right    (audio_right),
    .env_state      (env_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter since reset release; ticks fall on edges where cyc % 10 == 0.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int amag(input logic signed [15:0] a);
    return (a < 0) ? -int'(a) : int'(a);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    int e;
    int ft;
    int r;
    logic signed [15:0] v;
    logic signed [15:0] nv;
    logic s1;
    int vexp[8];
    vexp = '{0, 'h07F8, 'h0FF0, 'h1FE0, 'h2FD0, 'h3FBF, 'h3FBF, 'h3FBF};

    rst_n = 1'b0; div_l = 22'd1000; div_r = 22'd1; vol = 3'd3;
    step(3);
    chk("rst_audio_l", audio_left, 0);
    chk("rst_audio_r", audio_right, 0);
    chk("rst_state", env_state, 0);

    rst_n = 1'b1;
    step(1);
    chk("attack_entry", env_state, 1);
    found = 0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (env_state == 2'd2) begin found = 1; break; end
    end
    chk("sustain_found", found, 1);
    chk("sustain_edge", cyc, 161);
    step(2);
    chk("sus_mag_v3", amag(audio_left), 'h1FE0);
    chk("sus_right_silent", audio_right, 0);

    // Retrigger with a new left divider while sustaining.
    div_l = 22'd4; vol = 3'd5;
    step(1);
    chk("retrig_attack", env_state, 1);
    step(1);
    chk("retrig_sustain", env_state, 2);
    step(2);
    v = audio_left;
    found = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (audio_left != v) begin found = 1; break; end
    end
    chk("tone_edge_found", found, 1);
    v = audio_left; nv = -v;
    chk("tone_mag", amag(v), 'h3FBF);
    step(3);
    chk("tone_hold3", audio_left, v);
    step(1);
    chk("tone_flip4", audio_left, nv);

    for (int i = 0; i < 8; i++) begin
      vol = 3'(i);
      step(1);
      chk($sformatf("vol%0d_mag", i), amag(audio_left), vexp[i]);
    end
    vol = 3'd5;

    // Partial release to env = 127, then re-attack from there.
    div_l = 22'd1;
    step(1);
    e = cyc;
    chk("release_entry", env_state, 3);
    chk("release_tone_persists", int'(audio_left != 0), 1);
    ft = (e / 10 + 1) * 10;
    step(ft + 152 - cyc);
    chk("rel_env127_mag", amag(audio_left), 8127);
    chk("rel_still", env_state, 3);
    div_l = 22'd500;
    step(1);
    r = cyc;
    chk("reattack", env_state, 1);
    step(1);
    s1 = audio_left < 0;
    step(ft + 230 - cyc);
    chk("reattack_pre8", env_state, 1);
    step(1);
    chk("reattack_8ticks", env_state, 2);
    step(r + 500 - cyc);
    chk("osc_hold", int'(audio_left < 0), int'(s1));
    step(1);
    chk("osc_restart", int'(audio_left < 0), int'(!s1));

    // Full release to IDLE.
    div_l = 22'd1;
    step(1);
    e = cyc;
    chk("release2_entry", env_state, 3);
    ft = (e / 10 + 1) * 10;
    found = 0;
    for (int i = 0; i < 400; i++) begin
      step(1);
      if (env_state == 2'd0) begin found = 1; break; end
    end
    chk("idle_found", found, 1);
    chk("idle_edge", cyc, ft + 311);
    chk("idle_audio", audio_left, 0);

    // Right-only tone, then async reset mid-note.
    div_r = 22'd300;
    step(50);
    chk("pre_rst_right_active", int'(audio_right != 0), 1);
    rst_n = 1'b0;
    #2;
    chk("async_rst_right", audio_right, 0);
    chk("async_rst_state", env_state, 0);
    step(2);
    rst_n = 1'b1;
    found = 0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (env_state == 2'd2) begin found = 1; break; end
    end
    chk("r_sustain_found", found, 1);
    chk("r_sustain_edge", cyc, 161);
    chk("r_left_silent", audio_left, 0);
    v = audio_right;
    found = 0;
    for (int i = 0; i < 310; i++) begin
      step(1);
      if (audio_right != v) begin found = 1; break; end
    end
    chk("r_edge_found", found, 1);
    v = audio_right; nv = -v;
    chk("r_mag", amag(v), 'h3FBF);
    step(299);
    chk("r_hold299", audio_right, v);
    step(1);
    chk("r_flip300", audio_right, nv);
    chk("r_left_still_silent", audio_left, 0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
